// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle RV32I datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, owns the
// instruction register, drives datapath strobes and counts retirements.
// Optional build macro MULTICYCLE_CTRL_TRAP_EN: illegal opcodes park the
// FSM in TRAP (trap=1) until reset; without it they retire as a NOP.
//
// Memory handshake (imem and dmem alike): req is a registered output that
// stays high until ready is sampled high on a rising edge while req is
// high. Ready in the same cycle that req is high completes the access
// (zero wait states). Ready while req is low is ignored. Reset drops req
// asynchronously and owes no completion to the memory.
module multicycle_ctrl #(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [DW-1:0]    imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic [DW-1:0]    ir,
    output logic [2:0]       imm_sel,
    output logic             alu_src_imm,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    // Registered state and outputs
    state_t           state_q, state_d;
    logic [DW-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             imem_req_q, imem_req_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic             rf_we_q, rf_we_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic             trap_q, trap_d;
`endif

    // Combinational helpers
    logic [6:0] opc;
    logic       is_op, is_op_imm, is_load, is_store, is_branch;
    logic       is_jal, is_jalr, is_lui, is_auipc, is_legal;
    logic       retire;
    logic       pc_we_c;
    logic [1:0] pc_src_c;

    assign opc       = ir_q[6:0];
    assign is_op     = (opc == OPC_OP);
    assign is_op_imm = (opc == OPC_OP_IMM);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);
    assign is_lui    = (opc == OPC_LUI);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_legal  = is_op | is_op_imm | is_load | is_store | is_branch |
                       is_jal | is_jalr | is_lui | is_auipc;

    // Immediate-type select and ALU operand-B select decoded straight from ir
    always_comb begin
        imm_sel     = IMM_I;
        alu_src_imm = is_legal & ~is_op & ~is_branch;
        if (is_store) begin
            imm_sel = IMM_S;
        end else if (is_branch) begin
            imm_sel = IMM_B;
        end else if (is_lui || is_auipc) begin
            imm_sel = IMM_U;
        end else if (is_jal) begin
            imm_sel = IMM_J;
        end
    end

    // Next-state logic; pc_we/pc_src are the only outputs that react to inputs
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
        rf_we_d    = 1'b0;
        wb_sel_d   = WB_ALU;
        pc_we_c    = 1'b0;
        pc_src_c   = PC_PLUS4;
        retire     = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        trap_d     = trap_q;
`endif

        unique case (state_q)
            S_FETCH: begin
                imem_req_d = 1'b1;
                if (imem_req_q && imem_ready) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_DECODE;
                end
            end

            S_DECODE: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                if (!is_legal) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
`else
                state_d = S_EXEC;
`endif
            end

            S_EXEC: begin
                if (is_load || is_store) begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = is_store;
                    state_d    = S_MEM;
                end else if (is_branch) begin
                    pc_we_c    = 1'b1;
                    pc_src_c   = branch_taken ? PC_IMM : PC_PLUS4;
                    retire     = 1'b1;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_legal) begin
                    rf_we_d  = 1'b1;
                    wb_sel_d = (is_jal || is_jalr) ? WB_LINK : WB_ALU;
                    state_d  = S_WB;
                end else begin
                    // Illegal opcode retires as a NOP (never reached with trapping enabled)
                    pc_we_c    = 1'b1;
                    retire     = 1'b1;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_MEM: begin
                dmem_req_d = 1'b1;
                dmem_we_d  = dmem_we_q;
                if (dmem_req_q && dmem_ready) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    if (dmem_we_q) begin
                        pc_we_c    = 1'b1;
                        retire     = 1'b1;
                        imem_req_d = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        rf_we_d  = 1'b1;
                        wb_sel_d = WB_LOAD;
                        state_d  = S_WB;
                    end
                end
            end

            S_WB: begin
                pc_we_c    = 1'b1;
                pc_src_c   = is_jal ? PC_IMM : (is_jalr ? PC_JALR : PC_PLUS4);
                retire     = 1'b1;
                imem_req_d = 1'b1;
                state_d    = S_FETCH;
            end

            S_TRAP: begin
                // Parked until reset: no fetch, no PC update, counter frozen
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // State, instruction register, counter and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            instret_q  <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= WB_ALU;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            instret_q  <= instret_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            wb_sel_q   <= wb_sel_d;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            trap_q     <= trap_d;
`endif
        end
    end

    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign ir       = ir_q;
    assign pc_we    = pc_we_c;
    assign pc_src   = pc_src_c;
    assign rf_we    = rf_we_q;
    assign wb_sel   = wb_sel_q;
    assign instret  = instret_q;
    assign state    = state_q;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap     = trap_q;
`else
    assign trap     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. The counter is built 4 bits wide so
// the wrap from 2^CNT_W-1 to 0 is reached after sixteen retirements.
module tb_multicycle_ctrl;
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  localparam int K_WB  = 0;  // OP / OP-IMM / LUI / AUIPC / JAL / JALR
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_BR  = 3;
  localparam int K_ILL = 4;

  logic             clk;
  logic             rst_n;
  logic             imem_req;
  logic             imem_ready;
  logic [DW-1:0]    imem_rdata;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ready;
  logic             branch_taken;
  logic [DW-1:0]    ir;
  logic [2:0]       imm_sel;
  logic             alu_src_imm;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state;
  logic             trap;

  multicycle_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .ir(ir), .imm_sel(imm_sel),
    .alu_src_imm(alu_src_imm), .pc_we(pc_we), .pc_src(pc_src),
    .rf_we(rf_we), .wb_sel(wb_sel), .instret(instret), .state(state),
    .trap(trap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int steps = 0;
  logic [CNT_W-1:0] exp_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    steps++;
  endtask

  // driver: one full instruction, checking every state it passes through
  task automatic run_instr(input logic [31:0] instr, input int kind,
                           input logic [2:0] e_imm, input logic e_alu,
                           input logic [1:0] e_wb, input logic [1:0] e_pcs,
                           input int iwait, input int dwait, input logic taken);
    int n0;
    int dcnt;
    n0   = steps;
    dcnt = 0;
    chk("fetch_state", state, 0);
    chk("fetch_req", imem_req, 1);
    chk("fetch_pc_we", pc_we, 0);
    for (int i = 0; i < iwait; i++) begin
      imem_ready = 1'b0;
      step();
      chk("fetch_wait_state", state, 0);
      chk("fetch_wait_req", imem_req, 1);
    end
    imem_ready = 1'b1;
    imem_rdata = instr;
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEADBEEF;

    chk("dec_state", state, 1);
    chk("dec_ir", ir, instr);
    chk("dec_imm_sel", imm_sel, e_imm);
    chk("dec_alu_src_imm", alu_src_imm, e_alu);
    chk("dec_req", imem_req, 0);
    chk("dec_pc_we", pc_we, 0);
    chk("dec_rf_we", rf_we, 0);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    if (kind == K_ILL) begin
      step();
      chk("trap_state", state, 5);
      chk("trap_flag", trap, 1);
      chk("trap_req", imem_req, 0);
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        chk("trap_hold_state", state, 5);
        chk("trap_hold_req", imem_req, 0);
        chk("trap_hold_pc_we", pc_we, 0);
        chk("trap_hold_instret", instret, exp_ret);
      end
      imem_ready = 1'b0;
      return;
    end
`endif

    step();
    branch_taken = taken;
    #1;
    chk("exec_state", state, 2);
    chk("exec_ir", ir, instr);
    chk("exec_rf_we", rf_we, 0);
    chk("exec_dmem_req", dmem_req, 0);
    chk("exec_trap", trap, 0);

    if (kind == K_BR || kind == K_ILL) begin
      chk("exec_pc_we", pc_we, 1);
      chk("exec_pc_src", pc_src, e_pcs);
      exp_ret++;
      step();
      branch_taken = 1'b0;
      chk("exec_instret", instret, exp_ret);
      chk("exec_rf_we_after", rf_we, 0);
      return;
    end

    chk("exec_pc_we", pc_we, 0);
    step();

    if (kind == K_LD || kind == K_ST) begin
      for (int d = 0; d < dwait; d++) begin
        chk("mem_state", state, 3);
        chk("mem_req", dmem_req, 1);
        chk("mem_we", dmem_we, (kind == K_ST));
        chk("mem_pc_we", pc_we, 0);
        if (dmem_req) dcnt++;
        step();
      end
      dmem_ready = 1'b1;
      #1;
      chk("mem_done_req", dmem_req, 1);
      chk("mem_done_we", dmem_we, (kind == K_ST));
      if (dmem_req) dcnt++;
      if (kind == K_ST) begin
        chk("st_pc_we", pc_we, 1);
        chk("st_pc_src", pc_src, 0);
      end else begin
        chk("ld_pc_we", pc_we, 0);
      end
      step();
      dmem_ready = 1'b0;
      chk("dreq_cycles", dcnt, dwait + 1);
      chk("mem_req_drop", dmem_req, 0);
      if (kind == K_ST) begin
        exp_ret++;
        chk("st_no_wb_state", state, 0);
        chk("st_instret", instret, exp_ret);
        chk("st_rf_we", rf_we, 0);
        return;
      end
    end

    chk("wb_state", state, 4);
    chk("wb_rf_we", rf_we, 1);
    chk("wb_pc_we", pc_we, 1);
    chk("wb_sel", wb_sel, e_wb);
    chk("wb_pc_src", pc_src, e_pcs);
    exp_ret++;
    step();
    chk("wb_rf_we_after", rf_we, 0);
    chk("wb_pc_we_after", pc_we, 0);
    chk("wb_instret", instret, exp_ret);
    if (kind == K_WB && iwait == 0) chk("cycles_per_instr", steps - n0, 4);
  endtask

  // instructions used to walk the counter up to its wrap point
  logic [31:0] t_ins [5];
  logic [2:0]  t_imm [5];
  logic        t_alu [5];
  logic [1:0]  t_wb  [5];
  logic [1:0]  t_pcs [5];

  initial begin
    t_ins[0] = 32'h002081B3; t_imm[0] = 3'd0; t_alu[0] = 1'b0; t_wb[0] = 2'd0; t_pcs[0] = 2'd0; // ADD
    t_ins[1] = 32'h123450B7; t_imm[1] = 3'd3; t_alu[1] = 1'b1; t_wb[1] = 2'd0; t_pcs[1] = 2'd0; // LUI
    t_ins[2] = 32'h00001097; t_imm[2] = 3'd3; t_alu[2] = 1'b1; t_wb[2] = 2'd0; t_pcs[2] = 2'd0; // AUIPC
    t_ins[3] = 32'h008000EF; t_imm[3] = 3'd4; t_alu[3] = 1'b1; t_wb[3] = 2'd2; t_pcs[3] = 2'd1; // JAL
    t_ins[4] = 32'h00500093; t_imm[4] = 3'd0; t_alu[4] = 1'b1; t_wb[4] = 2'd0; t_pcs[4] = 2'd0; // ADDI

    rst_n        = 1'b0;
    imem_ready   = 1'b0;
    imem_rdata   = '0;
    dmem_ready   = 1'b0;
    branch_taken = 1'b0;
    exp_ret      = '0;

    #3;
    chk("rst_state", state, 0);
    chk("rst_ir", ir, 0);
    chk("rst_instret", instret, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_trap", trap, 0);
    chk("rst_imm_sel", imm_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ADDI, zero-wait fetch
    run_instr(32'h00500093, K_WB, 3'd0, 1'b1, 2'd0, 2'd0, 0, 0, 1'b0);
    chk("addi_instret", instret, 1);
    // LW with three wait states on the data port
    run_instr(32'h0000A103, K_LD, 3'd0, 1'b1, 2'd1, 2'd0, 1, 3, 1'b0);
    // SW, one data wait state
    run_instr(32'h0020A023, K_ST, 3'd1, 1'b1, 2'd0, 2'd0, 0, 1, 1'b0);
    // BEQ taken then not taken
    run_instr(32'h00000463, K_BR, 3'd2, 1'b0, 2'd0, 2'd1, 0, 0, 1'b1);
    run_instr(32'h00000463, K_BR, 3'd2, 1'b0, 2'd0, 2'd0, 2, 0, 1'b0);
    chk("after_branches", instret, 5);

    // ten more retirements bring the counter to 15
    for (int i = 0; i < 10; i++) begin
      run_instr(t_ins[i % 5], K_WB, t_imm[i % 5], t_alu[i % 5], t_wb[i % 5],
                t_pcs[i % 5], $urandom_range(0, 2), 0, 1'b0);
    end
    chk("pre_wrap", instret, 15);
    // JALR retires and the counter wraps
    run_instr(32'h000080E7, K_WB, 3'd0, 1'b1, 2'd2, 2'd2, 0, 0, 1'b0);
    chk("wrap", instret, 0);

    // illegal opcode: trap or NOP depending on build
    run_instr(32'h0000007F, K_ILL, 3'd0, 1'b0, 2'd0, 2'd0, 0, 0, 1'b0);

    // reset asserted between clock edges while a fetch (or the trap) is pending
    imem_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_imem_req", imem_req, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_instret", instret, 0);
    chk("mid_rst_ir", ir, 0);
    chk("mid_rst_trap", trap, 0);
    chk("mid_rst_pc_we", pc_we, 0);
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_instr(32'h00500093, K_WB, 3'd0, 1'b1, 2'd0, 2'd0, 0, 0, 1'b0);
    chk("post_rst_instret", instret, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
